// File: rtl/tone_synth_pkg.sv
// Shared types and constants for the tone synthesizer: FSM encoding, sample type,
// saturation limits and the default square-wave amplitude.
package tone_synth_pkg;

  localparam int HALF_PERIOD_W = 19;

  typedef logic signed [31:0] sample_t;

  typedef enum logic [1:0] {
    WAIT,
    WRITE,
    SETTLE
  } state_t;

  localparam sample_t SAMPLE_MAX        = 32'sh7FFF_FFFF;
  localparam sample_t SAMPLE_MIN        = 32'sh8000_0000;
  localparam sample_t DEFAULT_AMPLITUDE = 32'sd1000000000;

  // Signed add that clamps to the sample range instead of wrapping.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    if (sum[32] != sum[31]) begin
      return sum[32] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return sample_t'(sum[31:0]);
  endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Audio_Controller FIFO handshake and sample buses seen by the tone synthesizer.
// master = synthesizer side, slave = audio controller side.
interface tone_synth_if;
  import tone_synth_pkg::*;

  logic    audio_in_available;
  logic    audio_out_allowed;
  logic    read_audio_in;
  logic    write_audio_out;
  sample_t left_channel_audio_in;
  sample_t right_channel_audio_in;
  sample_t left_channel_audio_out;
  sample_t right_channel_audio_out;

  modport master (
    input  audio_in_available,
    input  audio_out_allowed,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_in_available,
    output audio_out_allowed,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );

endinterface

// File: rtl/tone_osc.sv
// Square-wave phase generator: toggles phase every half_period+1 cycles; a
// half_period of 0 (rest) parks counter and phase at 0.
module tone_osc
  import tone_synth_pkg::*;
(
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [HALF_PERIOD_W-1:0] half_period,
  output logic                     phase
);

  logic [HALF_PERIOD_W-1:0] count;

  // A shortened half-period that leaves count beyond it wraps at once rather than counting around.
  always_ff @(posedge CLOCK_50) begin
    if (reset || half_period == '0) begin
      count <= '0;
      phase <= 1'b0;
    end else if (count >= half_period) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Mixes a decaying square-wave tone into the microphone stream of the Audio_Controller.
// Define TONE_SYNTH_ENVELOPE_EN to compile in the per-note decay envelope.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter sample_t AMPLITUDE      = DEFAULT_AMPLITUDE,
  parameter int      DECAY_INTERVAL = 4800,
  parameter int      DECAY_SHIFT    = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [HALF_PERIOD_W-1:0] half_period,
  input  logic                     note_strobe,
  input  logic                     enable,
  tone_synth_if.master             audio
);

  state_t  state;
  state_t  state_next;
  logic    capture;
  logic    phase;
  sample_t level;
  sample_t tone;
  sample_t mix_left;
  sample_t mix_right;

  tone_osc u_osc (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .half_period (half_period),
    .phase       (phase)
  );

  always_comb begin
    tone = '0;
    if (enable && half_period != '0) begin
      tone = phase ? level : -level;
    end
    mix_left  = sat_add(audio.left_channel_audio_in, tone);
    mix_right = sat_add(audio.right_channel_audio_in, tone);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // SETTLE gives the controller one idle cycle to update its FIFO flags before the next check.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      WAIT: begin
        if (audio.audio_in_available && audio.audio_out_allowed) begin
          capture    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE:   state_next = SETTLE;
      SETTLE:  state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  assign audio.read_audio_in   = (state == WRITE);
  assign audio.write_audio_out = (state == WRITE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      audio.left_channel_audio_out  <= '0;
      audio.right_channel_audio_out <= '0;
    end else if (capture) begin
      audio.left_channel_audio_out  <= mix_left;
      audio.right_channel_audio_out <= mix_right;
    end
  end

`ifdef TONE_SYNTH_ENVELOPE_EN
  localparam logic [31:0] DECAY_LAST = 32'(DECAY_INTERVAL - 1);

  logic [31:0] decay_count;

  // A new note restores full level even when a decay step lands on the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset || note_strobe) begin
      level       <= AMPLITUDE;
      decay_count <= '0;
    end else if (state == WRITE) begin
      if (decay_count == DECAY_LAST) begin
        decay_count <= '0;
        level       <= level - (level >>> DECAY_SHIFT);
      end else begin
        decay_count <= decay_count + 1'b1;
      end
    end
  end
`else
  logic unused_envelope_cfg;

  assign level               = AMPLITUDE;
  assign unused_envelope_cfg = ^{note_strobe, 32'(DECAY_INTERVAL), 32'(DECAY_SHIFT)};
`endif

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
- REQ-001 Parameter AMPLITUDE, default 1000000000: peak square-wave magnitude, signed 32-bit.
- REQ-002 Parameter DECAY_INTERVAL, default 4800: samples written between envelope decay steps.
- REQ-003 Parameter DECAY_SHIFT, default 4: decay step is level minus (level >> DECAY_SHIFT).
- REQ-004 CLOCK_50  in  1  sole clock; all logic on rising edge.
- REQ-005 reset  in  1  synchronous, active-high reset.
- REQ-006 half_period  in  19  note half-period in CLOCK_50 cycles from the note RAM; 0 = rest.
- REQ-007 note_strobe  in  1  one-cycle pulse when the note address advances.
- REQ-008 enable  in  1  tone on; when low, tone contribution is 0.
- REQ-009 audio_in_available  in  1  Audio_Controller input FIFO non-empty.
- REQ-010 audio_out_allowed  in  1  Audio_Controller output FIFO has space.
- REQ-011 left_channel_audio_in, right_channel_audio_in  in  32 each  signed mic samples.
- REQ-012 read_audio_in  out  1  pops one input sample pair.
- REQ-013 write_audio_out  out  1  pushes one output sample pair.
- REQ-014 left_channel_audio_out, right_channel_audio_out  out  32 each  signed mixed samples.

Function
- REQ-015 Tone generator: 19-bit counter; counter == half_period -> counter 0, phase toggles; otherwise counter increments; full period 2*(half_period+1) cycles.
- REQ-016 Half-period change with counter > new half_period -> counter 0 and phase toggles next cycle; no counter wrap.
- REQ-017 half_period == 0 -> counter and phase held at 0, tone = 0.
- REQ-018 Tone = 0 if !enable or rest; +level if phase = 1; -level if phase = 0.
- REQ-019 Mix: out = in + tone, signed 32-bit, saturating at 32'h7FFFFFFF / 32'h80000000; per channel, same tone value for both.
- REQ-020 FSM states WAIT, WRITE, SETTLE; WAIT -> WRITE when audio_in_available & audio_out_allowed, capturing both mixed samples into output registers that cycle.
- REQ-021 WRITE: read_audio_in and write_audio_out both high for exactly one cycle; -> SETTLE.
- REQ-022 SETTLE: strobes low for one cycle (FIFO flags update); -> WAIT.
- REQ-023 Strobes never high outside WRITE; at most one transfer per 3 cycles; output data stable from capture until next capture.
- REQ-024 Envelope: note_strobe loads level = AMPLITUDE and clears decay counter; each WRITE cycle increments decay counter; at DECAY_INTERVAL-1 it clears and level <= level - (level >> DECAY_SHIFT).
- REQ-025 note_strobe coincident with a decay step -> load wins.
- REQ-026 note_strobe does not reset the tone counter or phase.

Reset
- REQ-027 reset -> state WAIT, tone counter 0, phase 0, level AMPLITUDE, decay counter 0, read_audio_in 0, write_audio_out 0, both audio outputs 0.
- REQ-028 reset asserted in WRITE -> strobes low in the following cycle; no partial transfer counted.
- REQ-029 reset dominates note_strobe and the FIFO handshake.

Configuration
- REQ-030 Macro TONE_SYNTH_ENVELOPE_EN defined: envelope per REQ-024/025 compiled in.
- REQ-031 Macro absent: level constant AMPLITUDE; decay counter logic absent; DECAY_* parameters ignored.

Structure
- REQ-032 Shared package holds FSM state encoding, 32-bit sample type, saturation limits, default AMPLITUDE.
- REQ-033 One sub-module, tone_osc: tone counter and phase (REQ-015..017); FSM, mixer, envelope in top.

Verification
- REQ-034 half_period = 3, enable = 1, no FIFO traffic -> phase toggles every 4 cycles, period 8.
- REQ-035 half_period 0, available & allowed held high -> write strobe every 3rd cycle; outputs equal inputs; strobe one cycle after condition.
- REQ-036 left_in = 32'h7FFFFFF0, phase 1, level 1000000000 -> left_out = 32'h7FFFFFFF; left_in = 32'h80000010, phase 0 -> 32'h80000000.
- REQ-037 Envelope build, DECAY_INTERVAL = 2, DECAY_SHIFT = 1, note_strobe then 4 writes -> level 1000000000 -> 500000000 -> 250000000; note_strobe restores 1000000000.
- REQ-038 reset pulsed during WRITE -> strobes low next cycle, outputs 0, state WAIT; audio_out_allowed low holds FSM in WAIT indefinitely.
